// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type bit positions, port directions, per-VC
// states and the dimension-ordered XY route function.
package noc_pkg;

  localparam int FT_HOF = 0;
  localparam int FT_BOF = 1;
  localparam int FT_EOF = 2;

  typedef enum logic [2:0] {
    DIR_S = 3'd0,
    DIR_W = 3'd1,
    DIR_N = 3'd2,
    DIR_E = 3'd3,
    DIR_L = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    VC_IDLE,
    VC_VA,
    VC_ACTIVE
  } vc_state_e;

  // X is resolved first, then Y (north = increasing y), then the local port.
  function automatic logic [4:0] xy_route(input logic [7:0] dx, input logic [7:0] dy,
                                          input logic [7:0] lx, input logic [7:0] ly);
    logic [4:0] r;
    r = '0;
    if (dx > lx)      r[DIR_E] = 1'b1;
    else if (dx < lx) r[DIR_W] = 1'b1;
    else if (dy > ly) r[DIR_N] = 1'b1;
    else if (dy < ly) r[DIR_S] = 1'b1;
    else              r[DIR_L] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC flit FIFO with occupancy count; head word reads as zero while empty.
module vc_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

endmodule

// File: rtl/sync_vc_inpbuf.sv
// Router input buffer: per-VC flit FIFOs, head-flit XY routing, VA/SA
// request generation and upstream credit return.
module sync_vc_inpbuf
  import noc_pkg::*;
#(
  parameter int DW    = 32,
  parameter int VCN   = 2,
  parameter int DEPTH = 4,
  parameter int DIR   = 0,
  parameter int SN    = 5,
  parameter int FT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [VCN-1:0]    in_vc,
  input  logic [DW-1:0]     in_d,
  input  logic [FT-1:0]     in_ft,
  output logic [VCN-1:0]    cor,
  output logic [VCN*SN-1:0] vcr,
  input  logic [VCN-1:0]    vcra,
  output logic [VCN-1:0]    swr,
  output logic [VCN-1:0]    swr_t,
  input  logic [VCN-1:0]    swa,
  output logic [VCN*DW-1:0] do_d,
  output logic [VCN*FT-1:0] do_ft,
  output logic [VCN*SN-1:0] dortg,
  input  logic [7:0]        addrx,
  input  logic [7:0]        addry,
  output logic              err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = DW + FT;

  logic           in_ok;
  logic [VCN-1:0] err_ev;
  logic           err_q, err_d;

  assign in_ok = in_vld & $onehot(in_vc);

  for (genvar v = 0; v < VCN; v++) begin : g_vc
    vc_state_e     state_q, state_d;
    logic [SN-1:0] route_q, route_d;
    logic          cor_q, cor_d;
    logic          wr_en, deq, ev;
    logic [FW-1:0] rdata;
    logic [CW-1:0] cnt;
    logic [DW-1:0] hd;
    logic [FT-1:0] hft;
    logic          nonempty, full;
    logic [SN-1:0] vcr_o, dortg_o;
    logic          swr_o, swr_t_o;

    vc_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data ({in_d, in_ft}),
      .rd_en   (deq),
      .rd_data (rdata),
      .count   (cnt)
    );

    assign hd       = rdata[FW-1:FT];
    assign hft      = rdata[FT-1:0];
    assign nonempty = (cnt != '0);
    assign full     = (cnt == CW'(DEPTH));

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= VC_IDLE;
        route_q <= '0;
        cor_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        route_q <= route_d;
        cor_q   <= cor_d;
      end
    end

    always_comb begin
      state_d = state_q;
      route_d = route_q;
      deq     = 1'b0;
      ev      = 1'b0;
      case (state_q)
        VC_IDLE: begin
          if (nonempty) begin
            if (hft[FT_HOF]) begin
              state_d = VC_VA;
              route_d = SN'(xy_route(hd[7:0], hd[15:8], addrx, addry));
              if (DIR != 4 && route_d[DIR]) ev = 1'b1;
            end else begin
              // Orphan body/tail flit: drop it but still hand the credit back.
              deq = 1'b1;
              ev  = 1'b1;
            end
          end
        end
        VC_VA: begin
          if (vcra[v]) state_d = VC_ACTIVE;
        end
        VC_ACTIVE: begin
          if (swa[v] && nonempty) begin
            deq = 1'b1;
            if (hft[FT_EOF]) state_d = VC_IDLE;
          end
        end
        default: state_d = VC_IDLE;
      endcase
      if (swa[v] && !(state_q == VC_ACTIVE && nonempty)) ev = 1'b1;
      // A full FIFO still accepts a write when the same cycle frees a slot.
      wr_en = in_ok & in_vc[v] & (~full | deq);
      if (in_ok && in_vc[v] && full && !deq) ev = 1'b1;
      cor_d = deq;
    end

    always_comb begin
      vcr_o   = '0;
      dortg_o = '0;
      swr_o   = 1'b0;
      swr_t_o = 1'b0;
      if (state_q == VC_VA) begin
        vcr_o   = route_q;
        dortg_o = route_q;
      end else if (state_q == VC_ACTIVE) begin
        dortg_o = route_q;
        swr_o   = nonempty;
        swr_t_o = nonempty & hft[FT_EOF];
      end
    end

    assign err_ev[v]           = ev;
    assign cor[v]              = cor_q;
    assign swr[v]              = swr_o;
    assign swr_t[v]            = swr_t_o;
    assign vcr[v*SN +: SN]     = vcr_o;
    assign dortg[v*SN +: SN]   = dortg_o;
    assign do_d[v*DW +: DW]    = hd;
    assign do_ft[v*FT +: FT]   = hft;
  end

  always_comb err_d = err_q | (in_vld & ~in_ok) | (|err_ev);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;

endmodule

// File: tb/tb_sync_vc_inpbuf.sv
// Directed table-driven bench for sync_vc_inpbuf plus hand sequences for
// overflow, VC interleaving, mid-packet reset and orphan flits.
module tb_sync_vc_inpbuf;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_vld;
  logic [1:0]  in_vc;
  logic [31:0] in_d;
  logic [2:0]  in_ft;
  logic [1:0]  cor;
  logic [9:0]  vcr;
  logic [1:0]  vcra;
  logic [1:0]  swr;
  logic [1:0]  swr_t;
  logic [1:0]  swa;
  logic [63:0] do_d;
  logic [5:0]  do_ft;
  logic [9:0]  dortg;
  logic [7:0]  addrx;
  logic [7:0]  addry;
  logic        err;

  int total = 0;
  int bad   = 0;

  sync_vc_inpbuf #(.DW(32), .VCN(2), .DEPTH(4), .DIR(0), .SN(5), .FT(3)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_vc(in_vc), .in_d(in_d), .in_ft(in_ft),
    .cor(cor), .vcr(vcr), .vcra(vcra), .swr(swr), .swr_t(swr_t), .swa(swa),
    .do_d(do_d), .do_ft(do_ft), .dortg(dortg), .addrx(addrx), .addry(addry), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [1:0]  vc;
    logic [31:0] d;
    logic [2:0]  ft;
    logic [1:0]  ra;
    logic [1:0]  sa;
    logic [1:0]  e_cor;
    logic [9:0]  e_vcr;
    logic [1:0]  e_swr;
    logic [1:0]  e_swrt;
    logic [9:0]  e_dortg;
    logic        e_err;
    logic [5:0]  e_doft;
    logic [63:0] e_dod;
  } vec_t;

  localparam logic [9:0] E0 = 10'b00000_01000;
  localparam logic [9:0] L1 = 10'b10000_00000;
  localparam logic [2:0] HOF = 3'b001, BOF = 3'b010, EOF = 3'b100, SGL = 3'b101;

  function automatic vec_t mk(logic vld, logic [1:0] vc, logic [31:0] d, logic [2:0] ft,
                              logic [1:0] ra, logic [1:0] sa, logic [1:0] e_cor,
                              logic [9:0] e_vcr, logic [1:0] e_swr, logic [1:0] e_swrt,
                              logic [9:0] e_dortg, logic e_err, logic [5:0] e_doft,
                              logic [63:0] e_dod);
    vec_t r;
    r.vld = vld; r.vc = vc; r.d = d; r.ft = ft; r.ra = ra; r.sa = sa;
    r.e_cor = e_cor; r.e_vcr = e_vcr; r.e_swr = e_swr; r.e_swrt = e_swrt;
    r.e_dortg = e_dortg; r.e_err = e_err; r.e_doft = e_doft; r.e_dod = e_dod;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] vc, input logic [31:0] d,
                     input logic [2:0] ft, input logic [1:0] ra, input logic [1:0] sa);
    in_vld = v; in_vc = vc; in_d = d; in_ft = ft; vcra = ra; swa = sa;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cor"},   64'(cor),   64'd0);
    chk({tag, "_vcr"},   64'(vcr),   64'd0);
    chk({tag, "_swr"},   64'(swr),   64'd0);
    chk({tag, "_swrt"},  64'(swr_t), 64'd0);
    chk({tag, "_dortg"}, 64'(dortg), 64'd0);
    chk({tag, "_err"},   64'(err),   64'd0);
    chk({tag, "_dod"},   do_d,       64'd0);
    chk({tag, "_doft"},  64'(do_ft), 64'd0);
  endtask

  vec_t tbl [12];

  localparam logic [31:0] D1 = 32'h0000_0102;
  localparam logic [31:0] D2 = 32'h1111_2222;
  localparam logic [31:0] D3 = 32'h3333_4444;
  localparam logic [31:0] DV = 32'hBEEF_0000;

  initial begin
    addrx = 8'd0;
    addry = 8'd0;
    rst = 1'b1;
    drv(0, 2'b00, '0, '0, 2'b00, 2'b00);
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;

    // 3-flit packet east on VC0, then single-flit local packet on VC1
    tbl[0]  = mk(1, 2'b01, D1, HOF, 2'b00, 2'b00, 2'b00, '0, 2'b00, 2'b00, '0, 0, 6'b000001, {32'h0, D1});
    tbl[1]  = mk(1, 2'b01, D2, BOF, 2'b00, 2'b00, 2'b00, E0, 2'b00, 2'b00, E0, 0, 6'b000001, {32'h0, D1});
    tbl[2]  = mk(1, 2'b01, D3, EOF, 2'b01, 2'b00, 2'b00, '0, 2'b01, 2'b00, E0, 0, 6'b000001, {32'h0, D1});
    tbl[3]  = mk(0, 2'b00, '0, '0,  2'b00, 2'b01, 2'b01, '0, 2'b01, 2'b00, E0, 0, 6'b000010, {32'h0, D2});
    tbl[4]  = mk(0, 2'b00, '0, '0,  2'b00, 2'b01, 2'b01, '0, 2'b01, 2'b01, E0, 0, 6'b000100, {32'h0, D3});
    tbl[5]  = mk(0, 2'b00, '0, '0,  2'b00, 2'b01, 2'b01, '0, 2'b00, 2'b00, '0, 0, 6'b000000, 64'h0);
    tbl[6]  = mk(0, 2'b00, '0, '0,  2'b00, 2'b00, 2'b00, '0, 2'b00, 2'b00, '0, 0, 6'b000000, 64'h0);
    tbl[7]  = mk(1, 2'b10, DV, SGL, 2'b00, 2'b00, 2'b00, '0, 2'b00, 2'b00, '0, 0, 6'b101000, {DV, 32'h0});
    tbl[8]  = mk(0, 2'b00, '0, '0,  2'b00, 2'b00, 2'b00, L1, 2'b00, 2'b00, L1, 0, 6'b101000, {DV, 32'h0});
    tbl[9]  = mk(0, 2'b00, '0, '0,  2'b10, 2'b00, 2'b00, '0, 2'b10, 2'b10, L1, 0, 6'b101000, {DV, 32'h0});
    tbl[10] = mk(0, 2'b00, '0, '0,  2'b00, 2'b10, 2'b10, '0, 2'b00, 2'b00, '0, 0, 6'b000000, 64'h0);
    tbl[11] = mk(0, 2'b00, '0, '0,  2'b00, 2'b00, 2'b00, '0, 2'b00, 2'b00, '0, 0, 6'b000000, 64'h0);

    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].vld, tbl[i].vc, tbl[i].d, tbl[i].ft, tbl[i].ra, tbl[i].sa);
      tick();
      chk($sformatf("row%0d_cor", i),   64'(cor),   64'(tbl[i].e_cor));
      chk($sformatf("row%0d_vcr", i),   64'(vcr),   64'(tbl[i].e_vcr));
      chk($sformatf("row%0d_swr", i),   64'(swr),   64'(tbl[i].e_swr));
      chk($sformatf("row%0d_swrt", i),  64'(swr_t), 64'(tbl[i].e_swrt));
      chk($sformatf("row%0d_dortg", i), 64'(dortg), 64'(tbl[i].e_dortg));
      chk($sformatf("row%0d_err", i),   64'(err),   64'(tbl[i].e_err));
      chk($sformatf("row%0d_doft", i),  64'(do_ft), 64'(tbl[i].e_doft));
      chk($sformatf("row%0d_dod", i),   do_d,       tbl[i].e_dod);
    end

    // Fill VC0 to DEPTH, full+swa write accepted, then overflow drop
    drv(1, 2'b01, 32'h5000_0000, HOF, 2'b00, 2'b00); tick();
    drv(1, 2'b01, 32'h5000_0001, BOF, 2'b00, 2'b00); tick();
    drv(1, 2'b01, 32'h5000_0002, BOF, 2'b00, 2'b00); tick();
    drv(1, 2'b01, 32'h5000_0003, BOF, 2'b00, 2'b00); tick();
    chk("fill_err", 64'(err), 64'd0);
    chk("fill_head", 64'(do_d[31:0]), 64'h5000_0000);
    chk("fill_vcr_local", 64'(vcr), 64'(10'b00000_10000));
    drv(0, 2'b00, '0, '0, 2'b01, 2'b00); tick();
    chk("fill_swr", 64'(swr), 64'd1);
    drv(1, 2'b01, 32'h5000_0004, EOF, 2'b00, 2'b01); tick();
    chk("full_swa_err", 64'(err), 64'd0);
    chk("full_swa_head", 64'(do_d[31:0]), 64'h5000_0001);
    chk("full_swa_cor", 64'(cor), 64'd1);
    drv(1, 2'b01, 32'h5000_0005, HOF, 2'b00, 2'b00); tick();
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_cor", 64'(cor), 64'd0);
    drv(0, 2'b00, '0, '0, 2'b00, 2'b01); tick();
    chk("drain1_head", 64'(do_d[31:0]), 64'h5000_0002);
    tick();
    chk("drain2_head", 64'(do_d[31:0]), 64'h5000_0003);
    tick();
    chk("drain3_head", 64'(do_d[31:0]), 64'h5000_0004);
    chk("drain3_swrt", 64'(swr_t), 64'd1);
    tick();
    chk("drain4_head", 64'(do_d[31:0]), 64'h0);
    chk("drain4_swr", 64'(swr), 64'd0);
    chk("drain4_cor", 64'(cor), 64'd1);

    drv(0, 2'b00, '0, '0, 2'b00, 2'b00);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_err", 64'(err), 64'd0);

    // VC0 active and VC1 in VA concurrently
    drv(1, 2'b01, 32'h0000_0102, HOF, 2'b00, 2'b00); tick();
    drv(1, 2'b01, 32'hA000_0001, BOF, 2'b00, 2'b00); tick();
    drv(1, 2'b10, 32'hB000_0000, SGL, 2'b01, 2'b00); tick();
    drv(1, 2'b01, 32'hA000_0002, EOF, 2'b00, 2'b00); tick();
    chk("ilv_c4_vcr", 64'(vcr), 64'(L1));
    chk("ilv_c4_dortg", 64'(dortg), 64'(10'b10000_01000));
    chk("ilv_c4_swr", 64'(swr), 64'd1);
    drv(0, 2'b00, '0, '0, 2'b00, 2'b01); tick();
    chk("ilv_c5_cor", 64'(cor), 64'd1);
    chk("ilv_c5_dod", do_d, {32'hB000_0000, 32'hA000_0001});
    chk("ilv_c5_vcr", 64'(vcr), 64'(L1));
    drv(0, 2'b00, '0, '0, 2'b10, 2'b00); tick();
    chk("ilv_c6_cor", 64'(cor), 64'd0);
    chk("ilv_c6_swr", 64'(swr), 64'd3);
    chk("ilv_c6_swrt", 64'(swr_t), 64'd2);
    drv(0, 2'b00, '0, '0, 2'b00, 2'b10); tick();
    chk("ilv_c7_cor", 64'(cor), 64'd2);
    chk("ilv_c7_dod", do_d, {32'h0, 32'hA000_0001});
    chk("ilv_c7_swr", 64'(swr), 64'd1);
    drv(0, 2'b00, '0, '0, 2'b00, 2'b01); tick();
    chk("ilv_c8_cor", 64'(cor), 64'd1);
    chk("ilv_c8_swrt", 64'(swr_t), 64'd1);
    tick();
    chk("ilv_c9_cor", 64'(cor), 64'd1);
    chk("ilv_c9_swr", 64'(swr), 64'd0);
    drv(0, 2'b00, '0, '0, 2'b00, 2'b00); tick();
    chk("ilv_c10_cor", 64'(cor), 64'd0);
    chk("ilv_c10_err", 64'(err), 64'd0);

    // Reset mid-packet with VC0 active holding 2 flits
    drv(1, 2'b01, 32'h0000_0102, HOF, 2'b00, 2'b00); tick();
    drv(1, 2'b01, 32'hC000_0001, BOF, 2'b00, 2'b00); tick();
    drv(0, 2'b00, '0, '0, 2'b01, 2'b00); tick();
    chk("mid_swr", 64'(swr), 64'd1);
    drv(0, 2'b00, '0, '0, 2'b00, 2'b01);
    rst = 1'b1; tick();
    chk_zero("midrst");
    rst = 1'b0;
    drv(0, 2'b00, '0, '0, 2'b00, 2'b00); tick();
    chk("midrst_nocor", 64'(cor), 64'd0);
    drv(1, 2'b01, 32'hC000_0102, SGL, 2'b00, 2'b00); tick();
    drv(0, 2'b00, '0, '0, 2'b00, 2'b00); tick();
    chk("post_rst_vcr", 64'(vcr), 64'(E0));
    chk("post_rst_dod", 64'(do_d[31:0]), 64'hC000_0102);

    // Orphan BOF on idle VC1
    drv(1, 2'b10, 32'hD000_0000, BOF, 2'b00, 2'b00); tick();
    chk("orph_doft", 64'(do_ft[5:3]), 64'(BOF));
    chk("orph_err0", 64'(err), 64'd0);
    drv(0, 2'b00, '0, '0, 2'b00, 2'b00); tick();
    chk("orph_err1", 64'(err), 64'd1);
    chk("orph_cor", 64'(cor), 64'd2);
    chk("orph_doft_gone", 64'(do_ft[5:3]), 64'd0);
    tick();
    chk("orph_cor_end", 64'(cor), 64'd0);
    chk("orph_vc0_vcr", 64'(vcr), 64'(E0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
